hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32 core: operand forwarding selects, load-use stall,

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard sequencer: forwarding selects,
// result-source codes, sequencer states and the register-match helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  // A producer feeds a consumer only when it writes back and is not x0.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic we);
    return we & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one Execute source register; the M-stage
// result is younger than the W-stage result, so it takes priority.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_match(rd_m_i, rs_i, reg_write_m_i)) begin
      sel_o = FWD_M;
    end else if (reg_match(rd_w_i, rs_i, reg_write_w_i)) begin
      sel_o = FWD_W;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: forwarding, load-use stall, branch flush and
// data-memory wait with timeout. Define HAZARD_PERF_EN to build the saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int              WC_W    = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO_VAL = WC_W'(MEM_TIMEOUT);
  localparam logic            TMO_EN  = (MEM_TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            lw_stall_s, mem_stall_s, tmo_s;

  fwd_sel u_fwd_a (
    .rs_i          (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .sel_o         (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs_i          (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .sel_o         (ForwardBE)
  );

  assign lw_stall_s = (ResultSrcE == RES_LOAD) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign tmo_s      = TMO_EN & (wait_cnt_q == TMO_VAL);

  // Sequencer state and memory wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state plus all stall/flush enables, same cycle as the inputs.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_stall_s = 1'b0;
    mem_err     = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    case (state_q)
      ST_INIT: begin
        StallF  = 1'b1;
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_req & ~mem_ready) begin
          mem_stall_s = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = WC_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // A completing access wins over a timeout landing on the same cycle.
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (tmo_s) begin
          state_d = ST_RUN;
          mem_err = 1'b1;
        end else begin
          mem_stall_s = 1'b1;
          wait_cnt_d  = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (state_q == ST_INIT) begin
      FlushW = 1'b0;
    end else if (mem_stall_s) begin
      // Freeze the whole pipe; D/E stay held so load-use and redirect are re-seen later.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall_s;
      StallD = lw_stall_s & ~PCSrcE;
      FlushE = lw_stall_s | PCSrcE;
      FlushD = PCSrcE;
      FlushW = mem_err;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
      if (mem_stall_s && (memwait_cnt_q != '1)) begin
        memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand sequences for reset,
// memory wait, timeout and counter saturation, compared through an expectation queue.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] ressrc;
    logic       regwm, regww, pcsrc, mreq, mrdy;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, sm, fd, fe, fw, err;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic       RegWriteM, RegWriteW, PCSrcE, mem_req, mem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [3:0] stall_cnt, flush_cnt, memwait_cnt;

  int   tests = 0;
  int   fails = 0;
  out_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  function automatic in_t mk_in(logic [4:0] rs1d, logic [4:0] rs2d, logic [4:0] rs1e,
                                logic [4:0] rs2e, logic [4:0] rde, logic [4:0] rdm,
                                logic [4:0] rdw, logic [1:0] ressrc, logic regwm,
                                logic regww, logic pcsrc, logic mreq, logic mrdy);
    in_t r;
    r = {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, ressrc, regwm, regww, pcsrc, mreq, mrdy};
    return r;
  endfunction

  function automatic out_t mk_out(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd,
                                  logic se, logic sm, logic fd, logic fe, logic fw,
                                  logic err);
    out_t r;
    r = {fa, fb, sf, sd, se, sm, fd, fe, fw, err};
    return r;
  endfunction

  task automatic apply(input in_t i);
    Rs1D = i.rs1d; Rs2D = i.rs2d; Rs1E = i.rs1e; Rs2E = i.rs2e;
    RdE = i.rde; RdM = i.rdm; RdW = i.rdw; ResultSrcE = i.ressrc;
    RegWriteM = i.regwm; RegWriteW = i.regww; PCSrcE = i.pcsrc;
    mem_req = i.mreq; mem_ready = i.mrdy;
  endtask

  task automatic check_out();
    out_t got, e;
    string n;
    got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %h, no expectation queued", got);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL %s: got %h required %h", n, got, e);
      end
    end
  endtask

  // One cycle: drive, queue the expectation, compare on the falling edge.
  task automatic step(input string n, input in_t i, input out_t e);
    apply(i);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string n, input logic [3:0] s, input logic [3:0] f,
                           input logic [3:0] m);
    @(negedge clk);
    tests++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== {s, f, m}) begin
      fails++;
      $display("FAIL %s: got s/f/m %0d/%0d/%0d required %0d/%0d/%0d",
               n, stall_cnt, flush_cnt, memwait_cnt, s, f, m);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  in_t  z, lw, mw;
  out_t o_zero, o_init, o_mem, o_err, o_lw;
  logic [3:0] es, ef, em;

  initial begin
    z      = '0;
    o_zero = '0;
    o_init = mk_out(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    o_mem  = mk_out(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    o_err  = mk_out(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    o_lw   = mk_out(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    lw     = mk_in(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mw     = mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    tbl[0]  = '{"fwd_m_beats_w", mk_in(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
                mk_out(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{"fwd_x0_never", mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
                o_zero};
    tbl[2]  = '{"fwd_w_both", mk_in(5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd4, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
                mk_out(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[3]  = '{"fwd_m_b_only", mk_in(5'd0, 5'd0, 5'd1, 5'd9, 5'd0, 5'd9, 5'd2, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
                mk_out(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[4]  = '{"fwd_no_regwrite", mk_in(5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                o_zero};
    tbl[5]  = '{"lw_stall_rs2", lw, o_lw};
    tbl[6]  = '{"lw_and_branch", mk_in(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                mk_out(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[7]  = '{"lw_rd_x0", mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                o_zero};
    tbl[8]  = '{"non_load_src", mk_in(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                o_zero};
    tbl[9]  = '{"branch_only", mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                mk_out(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[10] = '{"lw_stall_rs1", mk_in(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                o_lw};
    tbl[11] = '{"mem_ready_same_cycle", mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1),
                o_zero};

    // Reset held three cycles, then exactly one INIT cycle.
    apply(z);
    for (int i = 0; i < 3; i++) step("in_reset", z, o_init);
    reset = 1'b0;
    step("init_cycle", z, o_init);
    step("run_idle", z, o_zero);

    for (int i = 0; i < 12; i++) step(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Memory wait with pending load-use and branch suppressed, released by ready.
    step("mem_stall_override",
         mk_in(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), o_mem);
    for (int i = 0; i < 2; i++) step("mem_wait", mw, o_mem);
    step("mem_release", mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), o_zero);
    step("after_release", z, o_zero);

    // Timeout: four stalled cycles, then one abandon cycle.
    for (int i = 0; i < 4; i++) step("tmo_wait", mw, o_mem);
    step("tmo_err", mw, o_err);
    step("tmo_back_run", z, o_zero);

    // Ready arriving on the timeout cycle completes normally.
    for (int i = 0; i < 4; i++) step("edge_wait", mw, o_mem);
    step("ready_beats_tmo", mk_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), o_zero);

    // Reset mid-wait abandons the access silently.
    for (int i = 0; i < 2; i++) step("pre_reset_wait", mw, o_mem);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step("reset_mid_wait", mw, o_init);
    apply(z);
    reset = 1'b0;
    step("reinit_cycle", z, o_init);
    step("reinit_idle", z, o_zero);

`ifdef HAZARD_PERF_EN
    es = 4'd1; ef = 4'd1; em = 4'd0;
`else
    es = 4'd0; ef = 4'd0; em = 4'd0;
`endif
    check_cnt("cnt_after_reset", es, ef, em);

    for (int i = 0; i < 4; i++) step("cnt_tmo_wait", mw, o_mem);
    step("cnt_tmo_err", mw, o_err);
    apply(z);
`ifdef HAZARD_PERF_EN
    es = 4'd5; ef = 4'd1; em = 4'd4;
`endif
    check_cnt("cnt_after_memwait", es, ef, em);

    for (int i = 0; i < 20; i++) step("cnt_lw_stall", lw, o_lw);
    apply(z);
`ifdef HAZARD_PERF_EN
    es = 4'd15; ef = 4'd15; em = 4'd4;
`endif
    check_cnt("cnt_saturated", es, ef, em);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
